acc_out_deskew: RTL

Drain-side companion of the accumulator. It receives the column-skewed result stream the accumulator emits: column i is registered one cycle after column i-1 for each row read. It realigns the columns into whole rows, tags tile boundaries and optionally requantizes to activation width. Rows are buffered in a small FIFO and presented to the output buffer writer over a valid/ready handshake.

---
 rtl/gemm_pkg.sv | 23 ++
 rtl/acc_row_fifo.sv | 55 +++++
 rtl/acc_out_deskew.sv | 129 ++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared output-width and saturation helpers for the accumulator drain path.
// ACC_DESKEW_QUANT_EN selects the requantized (ACT_WIDTH) output lanes.
package gemm_pkg;

`ifdef ACC_DESKEW_QUANT_EN
    localparam bit QUANT_EN = 1'b1;
`else
    localparam bit QUANT_EN = 1'b0;
`endif

    function automatic int out_w(input int acc_w, input int act_w);
        return QUANT_EN ? act_w : acc_w;
    endfunction

    function automatic int sat_max(input int act_w);
        return (1 << (act_w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int act_w);
        return -(1 << (act_w - 1));
    endfunction

endpackage

// File: rtl/acc_row_fifo.sv
// rtl/acc_row_fifo.sv - row FIFO with parameterized depth and entry type.
// The head entry reads as all-zero while the FIFO is empty.
module acc_row_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  T                       i_push_data,
    input  logic                   i_pop,
    output T                       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_level;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_level <= r_level + (AW+1)'(1);
            else if (w_do_pop && !w_do_push) r_level <= r_level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    always_comb begin
        o_head = '0;
        if (!o_empty) o_head = r_mem[r_rd_ptr];
    end

endmodule

// File: rtl/acc_out_deskew.sv
// rtl/acc_out_deskew.sv - realigns the column-skewed accumulator stream into rows, tags tile ends, buffers rows.
// ACC_DESKEW_QUANT_EN enables per-lane shift-and-saturate to ACT_WIDTH before the FIFO.
module acc_out_deskew
    import gemm_pkg::*;
#(
    parameter int  SYS_ARRAY_HEIGHT = 8,
    parameter int  SYS_ARRAY_WIDTH  = 8,
    parameter int  ACC_WIDTH        = 32,
    parameter int  ACT_WIDTH        = 8,
    parameter int  FIFO_DEPTH       = 4,
    localparam int OUT_W            = out_w(ACC_WIDTH, ACT_WIDTH),
    localparam int LVL_W            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  acc_data_oen,
    input  logic [SYS_ARRAY_WIDTH-1:0][ACC_WIDTH-1:0] fact_data_in,
    input  logic                                  done,
    input  logic [4:0]                            q_shift,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [SYS_ARRAY_WIDTH-1:0][OUT_W-1:0] out_data,
    output logic                                  out_last,
    output logic [LVL_W-1:0]                      fifo_level,
    output logic                                  overflow_err
);
    localparam int W     = SYS_ARRAY_WIDTH;
    localparam int CNT_W = (SYS_ARRAY_HEIGHT > 1) ? $clog2(SYS_ARRAY_HEIGHT) : 1;

    typedef struct packed {
        logic [W-1:0][OUT_W-1:0] data;
        logic                    last;
    } row_t;

    logic [W-1:0]                r_stb;
    logic [CNT_W-1:0]            r_row_cnt;
    logic                        r_overflow;
    logic [W-1:0][ACC_WIDTH-1:0] w_aligned;
    logic [W-1:0][OUT_W-1:0]     w_lane_out;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_accept;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_last;
    row_t                        w_in_row;
    row_t                        w_head;

    // r_stb[i] is the row strobe delayed i+1 cycles: the capture enable for column i.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_stb <= '0;
        else        r_stb <= {r_stb[W-2:0], acc_data_oen};
    end

    for (genvar i = 0; i < W - 1; i++) begin : g_line
        localparam int D = W - 1 - i;
        logic [ACC_WIDTH-1:0] r_line [D];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k < D; k++) r_line[k] <= '0;
            end else begin
                if (r_stb[i]) r_line[0] <= fact_data_in[i];
                for (int k = 1; k < D; k++) r_line[k] <= r_line[k-1];
            end
        end

        assign w_aligned[i] = r_line[D-1];
    end
    assign w_aligned[W-1] = fact_data_in[W-1];

`ifdef ACC_DESKEW_QUANT_EN
    localparam logic signed [ACC_WIDTH-1:0] L_MAX = ACC_WIDTH'(sat_max(ACT_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] L_MIN = ACC_WIDTH'(sat_min(ACT_WIDTH));

    for (genvar i = 0; i < W; i++) begin : g_quant
        logic signed [ACC_WIDTH-1:0] w_shifted;
        assign w_shifted     = $signed(w_aligned[i]) >>> q_shift;
        assign w_lane_out[i] = (w_shifted > L_MAX) ? L_MAX[OUT_W-1:0] :
                               (w_shifted < L_MIN) ? L_MIN[OUT_W-1:0] :
                                                     w_shifted[OUT_W-1:0];
    end
`else
    logic w_unused_q;
    assign w_unused_q = ^q_shift;
    assign w_lane_out = w_aligned;
`endif

    assign w_push        = r_stb[W-1];
    assign w_pop         = out_valid & out_ready;
    assign w_last        = (r_row_cnt == CNT_W'(SYS_ARRAY_HEIGHT - 1));
    assign w_accept      = w_push & (~w_full | w_pop);
    assign w_in_row.data = w_lane_out;
    assign w_in_row.last = w_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (done)        r_row_cnt <= '0;
            else if (w_push) r_row_cnt <= w_last ? '0 : r_row_cnt + CNT_W'(1);

            if (w_push && !w_accept) r_overflow <= 1'b1;
            else if (done)           r_overflow <= 1'b0;
        end
    end

    acc_row_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (row_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_accept),
        .i_push_data (w_in_row),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

    assign out_valid    = ~w_empty;
    assign out_data     = w_head.data;
    assign out_last     = w_head.last;
    assign overflow_err = r_overflow;

endmodule
